// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 matrix multiplier datapath and its stream loader.
package matmul_pkg;

  localparam int unsigned MAT_N     = 3;
  localparam int unsigned MAT_ELEMS = MAT_N * MAT_N;
  localparam int unsigned DATA_W    = 32;

  typedef logic [DATA_W-1:0] mat_elem_t;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    FULL
  } matload_state_t;

endpackage

// File: rtl/matload_idx_ctr.sv
// Mod-9 element index counter with row/column decode for the matrix stream loader.
// clr_i has priority over set1_i, which has priority over en_i.
module matload_idx_ctr
  import matmul_pkg::*;
(
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       set1_i,
  input  logic       en_i,
  output logic [3:0] idx_o,
  output logic [1:0] row_o,
  output logic [1:0] col_o,
  output logic       last_o
);

  logic [3:0] idx_q, idx_d;

  // Next index: clear, jump to 1 (start-of-frame beat already stored), or wrap-around increment.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (set1_i) begin
      idx_d = 4'd1;
    end else if (en_i) begin
      idx_d = (idx_q == 4'(MAT_ELEMS - 1)) ? '0 : idx_q + 4'd1;
    end
  end

  // Index register; clr_i doubles as the synchronous reset.
  always_ff @(posedge clk_i) begin
    idx_q <= idx_d;
  end

  // Row-major decode of the current index.
  always_comb begin
    row_o  = 2'(idx_q / 4'(MAT_N));
    col_o  = 2'(idx_q % 4'(MAT_N));
    last_o = (idx_q == 4'(MAT_ELEMS - 1));
    idx_o  = idx_q;
  end

endmodule

// File: rtl/matrix_stream_loader.sv
// Assembles a serial valid/ready word stream into 3x3 matrices A then B and holds them
// until the consumer acknowledges.
// Build option: define MATLOAD_B_COLMAJOR_EN to take the B beats in column-major order.
module matrix_stream_loader #(
  parameter int unsigned DATA_W = matmul_pkg::DATA_W,
  parameter int unsigned N      = matmul_pkg::MAT_N
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  input  logic                         in_sof,
  output logic                         in_ready,
  output logic [0:2][0:2][DATA_W-1:0]  a_mat,
  output logic [0:2][0:2][DATA_W-1:0]  b_mat,
  output logic                         mat_valid,
  input  logic                         mat_ack,
  output logic                         frame_err
);
  import matmul_pkg::*;

  if (N != MAT_N) begin : gen_bad_n
    $error("matrix_stream_loader: N must be 3");
  end

  matload_state_t state_q, state_d;
  logic [0:2][0:2][DATA_W-1:0] a_q, b_q;
  logic       frame_err_q, err_d;
  logic       accept, sof_beat;
  logic       a_we, b_we;
  logic [3:0] idx;
  logic [1:0] row, col;
  logic [1:0] a_row, a_col, b_row, b_col;
  logic       last;

  assign in_ready = (state_q != FULL) && !rst;
  assign accept   = in_valid && in_ready;
  assign sof_beat = accept && in_sof;

  matload_idx_ctr u_idx_ctr (
    .clk_i  (clk),
    .clr_i  (rst),
    .set1_i (sof_beat),
    .en_i   (accept && !in_sof),
    .idx_o  (idx),
    .row_o  (row),
    .col_o  (col),
    .last_o (last)
  );

  // A start-of-frame beat always lands in A[0][0].
  assign a_row = sof_beat ? 2'd0 : row;
  assign a_col = sof_beat ? 2'd0 : col;

`ifdef MATLOAD_B_COLMAJOR_EN
  assign b_row = col;
  assign b_col = row;
`else
  assign b_row = row;
  assign b_col = col;
`endif

  // Next-state, write enables and protocol error detection.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    if (sof_beat) begin
      state_d = LOAD_A;
      a_we    = 1'b1;
      err_d   = !((state_q == LOAD_A) && (idx == 4'd0));
    end else if (accept) begin
      case (state_q)
        LOAD_A: begin
          a_we = 1'b1;
          if (last) state_d = LOAD_B;
        end
        LOAD_B: begin
          b_we = 1'b1;
          if (last) state_d = FULL;
        end
        default: ;
      endcase
    end else if ((state_q == FULL) && mat_ack) begin
      state_d = LOAD_A;
    end
  end

  // State and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD_A;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= err_d;
    end
  end

  // Matrix storage; no writes can occur in FULL because in_ready is low there.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (a_we) a_q[a_row][a_col] <= in_data;
      if (b_we) b_q[b_row][b_col] <= in_data;
    end
  end

  assign a_mat     = a_q;
  assign b_mat     = b_q;
  assign mat_valid = (state_q == FULL);
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader with a frame-level reference model.
module tb_matrix_stream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, in_valid, in_sof, mat_ack;
  logic [31:0]           in_data;
  logic                  in_ready, mat_valid, frame_err;
  logic [0:2][0:2][31:0] a_mat, b_mat;

  matrix_stream_loader #(.DATA_W(32), .N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .a_mat     (a_mat),
    .b_mat     (b_mat),
    .mat_valid (mat_valid),
    .mat_ack   (mat_ack),
    .frame_err (frame_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: flat row-major images of A and B plus load progress.
  logic [31:0] exp_a [9];
  logic [31:0] exp_b [9];
  int          m_phase;  // 0 = filling A, 1 = filling B, 2 = complete
  int          m_cnt;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      exp_a[i] = '0;
      exp_b[i] = '0;
    end
    m_phase = 0;
    m_cnt   = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_accept(input logic [31:0] d, input logic sof);
    m_err = 1'b0;
    if (sof) begin
      m_err    = !(m_phase == 0 && m_cnt == 0);
      exp_a[0] = d;
      m_phase  = 0;
      m_cnt    = 1;
    end else if (m_phase == 0) begin
      exp_a[m_cnt] = d;
      m_cnt++;
      if (m_cnt == 9) begin
        m_phase = 1;
        m_cnt   = 0;
      end
    end else if (m_phase == 1) begin
`ifdef MATLOAD_B_COLMAJOR_EN
      exp_b[(m_cnt % 3) * 3 + m_cnt / 3] = d;
`else
      exp_b[m_cnt] = d;
`endif
      m_cnt++;
      if (m_cnt == 9) begin
        m_phase = 2;
        m_cnt   = 0;
      end
    end
  endtask

  task automatic check_arrays(input string tag);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        check($sformatf("%s_a[%0d][%0d]", tag, r, c), a_mat[r][c], exp_a[r*3+c]);
        check($sformatf("%s_b[%0d][%0d]", tag, r, c), b_mat[r][c], exp_b[r*3+c]);
      end
    end
  endtask

  // Present one beat (optionally after random idle cycles) and wait for it to be taken.
  task automatic send_beat(input logic [31:0] d, input logic sof, input bit gaps);
    int n;
    if (gaps) begin
      n = 0;
      while ($urandom_range(0, 1) == 1 && n < 8) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        n++;
      end
    end
    in_data  = d;
    in_sof   = sof;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("ready_timeout", in_ready, 1);
    @(posedge clk); #1;
    model_accept(d, sof);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check("frame_err_beat", frame_err, m_err);
  endtask

  task automatic send_beats(input int count, input logic [31:0] base, input bit first_sof,
                            input bit gaps, input bit rnd);
    for (int i = 0; i < count; i++) begin
      send_beat(rnd ? $urandom : base + i, first_sof && (i == 0), gaps);
    end
  endtask

  task automatic do_ack();
    in_valid = 1'b0;
    mat_ack  = 1'b1;
    @(posedge clk); #1;
    mat_ack  = 1'b0;
    m_phase  = 0;
    check("ack_mat_valid", mat_valid, 0);
    check("ack_in_ready", in_ready, 1);
  endtask

  logic [31:0] c_val;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    mat_ack  = 1'b0;
    in_data  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mat_valid", mat_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check_arrays("rst");
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Frame 1: 1..9 then 10..18, sof on the first beat.
    send_beats(17, 32'd1, 1'b1, 1'b0, 1'b0);
    check("mv_before_last", mat_valid, 0);
    send_beat(32'd18, 1'b0, 1'b0);
    check("mv_after_last", mat_valid, 1);
    check("a12", a_mat[1][2], 32'd6);
`ifdef MATLOAD_B_COLMAJOR_EN
    check("b20_colmajor", b_mat[2][0], 32'd12);
    check("b01_colmajor", b_mat[0][1], 32'd13);
`else
    check("b20", b_mat[2][0], 32'd16);
`endif
    check_arrays("frame1");

    // Hold in FULL with in_valid asserted; nothing may move.
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = $urandom;
      @(posedge clk); #1;
      check("hold_in_ready", in_ready, 0);
      check("hold_mat_valid", mat_valid, 1);
    end
    check_arrays("hold");
    do_ack();

    // Restart mid-frame: 5 A beats, then sof beat 0xAA; ack held high meanwhile is ignored.
    mat_ack = 1'b1;
    send_beats(5, 32'h100, 1'b0, 1'b0, 1'b0);
    mat_ack = 1'b0;
    send_beat(32'hAA, 1'b1, 1'b0);
    check("sof_err_pulse", frame_err, 1);
    check("sof_a00", a_mat[0][0], 32'hAA);
    @(posedge clk); #1;
    check("sof_err_drop", frame_err, 0);
    send_beats(17, 32'h200, 1'b0, 1'b0, 1'b0);
    check("restart_mat_valid", mat_valid, 1);
    check_arrays("restart");
    do_ack();

    // Three consecutive random frames with random valid gaps.
    for (int f = 0; f < 3; f++) begin
      send_beats(18, 32'd0, f[0], 1'b1, 1'b1);
      check("rnd_mat_valid", mat_valid, 1);
      check_arrays("rnd");
      do_ack();
    end

    // A = identity, B = 1..9: product must equal B.
    for (int i = 0; i < 9; i++) send_beat((i % 4 == 0) ? 32'd1 : 32'd0, i == 0, 1'b0);
    send_beats(9, 32'd1, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        c_val = '0;
        for (int k = 0; k < 3; k++) c_val += a_mat[r][k] * b_mat[k][c];
        check($sformatf("matmul_c[%0d][%0d]", r, c), c_val, exp_b[r*3+c]);
      end
    end
    do_ack();

    // Reset after 12 beats, then a fresh frame without sof.
    send_beats(12, 32'h300, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check("midrst_mat_valid", mat_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check_arrays("midrst");
    rst = 1'b0;
    #1;
    send_beats(18, 32'h400, 1'b0, 1'b0, 1'b0);
    check("fresh_mat_valid", mat_valid, 1);
    check_arrays("fresh");
    do_ack();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
